// File: rtl/types_pkg.sv
// Shared state encodings for the cipher host-side handshake controllers.
package types_pkg;

  typedef enum logic [1:0] {
    I_IDLE       = 2'd0,
    I_PROCESSING = 2'd1,
    I_DONE       = 2'd2
  } interface_state_t;

  typedef enum logic [1:0] {
    B_IDLE       = 2'd0,
    B_PROCESSING = 2'd1,
    B_DONE       = 2'd2,
    B_ERROR      = 2'd3
  } burst_state_t;

endpackage

// File: rtl/state_timeout_counter.sv
// Counts cycles spent in the current state; expired flags the last cycle before timeout.
module state_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_INT);

  if (TIMEOUT == 0) begin : g_off
    logic unused_in;
    assign unused_in = clk ^ rst ^ clear ^ enable;
    assign expired   = 1'b0;
  end else begin : g_on
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        count <= '0;
      end else if (enable) begin
        count <= count + CW'(1);
      end
    end

    assign expired = (count == LAST);
  end

endmodule

// File: rtl/burst_interface_fsm.sv
// Multi-word request/process/acknowledge controller between host pins, cipher core and output holder.
module burst_interface_fsm
  import types_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_request,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             output_is_ready,
  input  logic             output_acknowledge,
  input  logic             abort,
  input  logic             error_clear,
  output burst_state_t     state_out,
  output logic [LEN_W-1:0] word_index,
  output logic             load_word,
  output logic             output_valid,
  output logic             msg_done,
  output logic             error
);

  burst_state_t     state_next;
  logic [LEN_W-1:0] len_q, len_next, idx_next;
  logic             load_next, done_next;
  logic             expired, tmo_enable, tmo_clear;

  assign tmo_enable = (state_out == B_PROCESSING) || (state_out == B_DONE);
  // Any state change, including DONE->PROCESSING, restarts the per-state timer.
  assign tmo_clear  = (state_next != state_out);

  state_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (expired)
  );

  // Next state: abort beats the exit event, which beats timeout.
  always_comb begin
    state_next = state_out;
    idx_next   = word_index;
    len_next   = len_q;
    load_next  = 1'b0;
    done_next  = 1'b0;
    case (state_out)
      B_IDLE: begin
        if (input_request) begin
          state_next = B_PROCESSING;
          len_next   = msg_len;
          idx_next   = '0;
          load_next  = 1'b1;
        end
      end
      B_PROCESSING: begin
        if (abort) begin
          state_next = B_IDLE;
          idx_next   = '0;
        end else if (output_is_ready) begin
          state_next = B_DONE;
        end else if (expired) begin
          state_next = B_ERROR;
        end
      end
      B_DONE: begin
        if (abort) begin
          state_next = B_IDLE;
          idx_next   = '0;
        end else if (output_acknowledge) begin
          if (word_index == len_q) begin
            state_next = B_IDLE;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            state_next = B_PROCESSING;
            idx_next   = word_index + LEN_W'(1);
            load_next  = 1'b1;
          end
        end else if (expired) begin
          state_next = B_ERROR;
        end
      end
      B_ERROR: begin
        if (error_clear || abort) begin
          state_next = B_IDLE;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = B_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_out    <= B_IDLE;
      word_index   <= '0;
      len_q        <= '0;
      load_word    <= 1'b0;
      msg_done     <= 1'b0;
      output_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_out    <= state_next;
      word_index   <= idx_next;
      len_q        <= len_next;
      load_word    <= load_next;
      msg_done     <= done_next;
      output_valid <= (state_next == B_DONE);
      error        <= (state_next == B_ERROR);
    end
  end

endmodule

// File: tb/tb_burst_interface_fsm.sv
// Directed bench for burst_interface_fsm with a scoreboard of expected load_word indices.
module tb_burst_interface_fsm;
  import types_pkg::*;

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             input_request = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic             output_is_ready = 1'b0;
  logic             output_acknowledge = 1'b0;
  logic             abort = 1'b0;
  logic             error_clear = 1'b0;
  burst_state_t     state_out;
  logic [LEN_W-1:0] word_index;
  logic             load_word, output_valid, msg_done, error;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int done_cnt = 0;
  int unsigned exp_q[$];

  burst_interface_fsm #(
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .input_request      (input_request),
    .msg_len            (msg_len),
    .output_is_ready    (output_is_ready),
    .output_acknowledge (output_acknowledge),
    .abort              (abort),
    .error_clear        (error_clear),
    .state_out          (state_out),
    .word_index         (word_index),
    .load_word          (load_word),
    .output_valid       (output_valid),
    .msg_done           (msg_done),
    .error              (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 ns after the edge, and score any load_word pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (load_word) begin
      load_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL load_extra: observed load_word at word_index %0d expected no load", word_index);
      end
      if (exp_q.size() != 0) chk("load_idx", 32'(word_index), exp_q.pop_front());
    end
    if (msg_done) done_cnt++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state_out), 32'(B_IDLE));
    chk({tag, "_idx"},   32'(word_index), 0);
    chk({tag, "_load"},  32'(load_word), 0);
    chk({tag, "_valid"}, 32'(output_valid), 0);
    chk({tag, "_done"},  32'(msg_done), 0);
    chk({tag, "_err"},   32'(error), 0);
  endtask

  // Full message of len+1 words; ready is raised after 'delay' extra cycles in each PROCESSING visit.
  task automatic run_msg(input int unsigned len, input int unsigned delay);
    int l0, d0;
    l0 = load_cnt;
    d0 = done_cnt;
    msg_len = LEN_W'(len);
    input_request = 1'b1;
    exp_q.push_back(0);
    tick();
    input_request = 1'b0;
    for (int w = 0; w <= int'(len); w++) begin
      chk("proc_state", 32'(state_out), 32'(B_PROCESSING));
      chk("proc_idx", 32'(word_index), 32'(w));
      repeat (delay) tick();
      chk("proc_noload", 32'(load_word), 0);
      output_is_ready = 1'b1;
      tick();
      output_is_ready = 1'b0;
      chk("valid", 32'(output_valid), 1);
      chk("done_state", 32'(state_out), 32'(B_DONE));
      output_acknowledge = 1'b1;
      if (w != int'(len)) exp_q.push_back(32'(w + 1));
      tick();
      output_acknowledge = 1'b0;
    end
    chk("msg_done_pulse", 32'(msg_done), 1);
    chk("end_state", 32'(state_out), 32'(B_IDLE));
    chk("end_idx", 32'(word_index), 0);
    tick();
    chk("msg_done_clear", 32'(msg_done), 0);
    chk("load_count", 32'(load_cnt - l0), len + 1);
    chk("done_count", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    int l0, d0;
    // Reset
    repeat (2) tick();
    rst = 1'b0;
    chk_reset_outputs("reset");
    tick();
    chk_reset_outputs("idle");

    // Single word: load at cycle 1, ready in cycle 5, valid at 6, msg_done at 7
    run_msg(0, 4);

    // Four words and maximum length
    run_msg(3, 2);
    run_msg(15, 1);

    // Timeout in PROCESSING: 8 cycles without ready
    msg_len = '0;
    input_request = 1'b1;
    exp_q.push_back(0);
    tick();
    input_request = 1'b0;
    repeat (7) tick();
    chk("tmo_8th_cycle", 32'(state_out), 32'(B_PROCESSING));
    tick();
    chk("tmo_state", 32'(state_out), 32'(B_ERROR));
    chk("tmo_err", 32'(error), 1);
    input_request = 1'b1;
    repeat (3) tick();
    input_request = 1'b0;
    chk("err_hold", 32'(state_out), 32'(B_ERROR));
    error_clear = 1'b1;
    abort = 1'b1;
    tick();
    error_clear = 1'b0;
    abort = 1'b0;
    chk_reset_outputs("err_clear");

    // Ready in the 8th cycle wins over timeout; then DONE times out; abort leaves ERROR
    input_request = 1'b1;
    exp_q.push_back(0);
    tick();
    input_request = 1'b0;
    repeat (7) tick();
    output_is_ready = 1'b1;
    tick();
    output_is_ready = 1'b0;
    chk("ready_beats_tmo", 32'(state_out), 32'(B_DONE));
    repeat (7) tick();
    chk("done_8th_cycle", 32'(state_out), 32'(B_DONE));
    tick();
    chk("done_tmo", 32'(state_out), 32'(B_ERROR));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_reset_outputs("err_abort");

    // Abort in DONE of the second of four words, together with ack
    l0 = load_cnt;
    d0 = done_cnt;
    msg_len = LEN_W'(3);
    input_request = 1'b1;
    exp_q.push_back(0);
    tick();
    input_request = 1'b0;
    output_is_ready = 1'b1;
    tick();
    output_is_ready = 1'b0;
    output_acknowledge = 1'b1;
    exp_q.push_back(1);
    tick();
    output_acknowledge = 1'b0;
    output_is_ready = 1'b1;
    tick();
    output_is_ready = 1'b0;
    chk("abort_pre_idx", 32'(word_index), 1);
    output_acknowledge = 1'b1;
    abort = 1'b1;
    tick();
    output_acknowledge = 1'b0;
    abort = 1'b0;
    chk_reset_outputs("abort");
    tick();
    chk("abort_loads", 32'(load_cnt - l0), 2);
    chk("abort_no_done", 32'(done_cnt - d0), 0);

    // Request accepted in the msg_done cycle
    msg_len = '0;
    input_request = 1'b1;
    exp_q.push_back(0);
    tick();
    input_request = 1'b0;
    output_is_ready = 1'b1;
    tick();
    output_is_ready = 1'b0;
    output_acknowledge = 1'b1;
    tick();
    output_acknowledge = 1'b0;
    chk("b2b_done", 32'(msg_done), 1);
    input_request = 1'b1;
    exp_q.push_back(0);
    tick();
    input_request = 1'b0;
    chk("b2b_state", 32'(state_out), 32'(B_PROCESSING));
    chk("b2b_load", 32'(load_word), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("b2b_abort", 32'(state_out), 32'(B_IDLE));

    // Reset mid-message, then a normal message
    msg_len = LEN_W'(3);
    input_request = 1'b1;
    exp_q.push_back(0);
    tick();
    input_request = 1'b0;
    tick();
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("mid_rst");
    chk("mid_rst_no_done", 32'(done_cnt - d0), 0);
    run_msg(1, 2);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
